// File: rtl/core_ctrl_fsm_if.sv
// core_ctrl_fsm_if: instruction and data memory handshake bundle used by core_ctrl_fsm.
// master = sequencer side, slave = memory side.
interface core_ctrl_fsm_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_rsp_valid;

    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output dmem_req_valid,
        input  dmem_req_ready,
        input  dmem_rsp_valid
    );

    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  dmem_req_valid,
        output dmem_req_ready,
        output dmem_rsp_valid
    );
endinterface

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/memory/writeback sequencer for the NPC core.
// Define PERF_CNT_EN to add the perf_cycle / perf_instret counters.
module core_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned TO_W           = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    core_ctrl_fsm_if.master io_mem,
    output logic [31:0]     o_inst,
    input  logic            i_dec_is_mem,
    input  logic            i_dec_wr_rd,
    input  logic            i_dec_is_ebreak,
    output logic            o_rf_wen,
    output logic            o_pc_wen,
    output logic            o_halted,
    output logic            o_fault,
    output logic [2:0]      o_state
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]     o_perf_cycle,
    output logic [63:0]     o_perf_instret
`endif
);

    // state   | meaning
    // FETCH   | imem request held until accepted
    // WAIT_I  | waiting for instruction word, captured into inst
    // DECODE  | one cycle, decoder flags select HALT / MEM / WB
    // MEM     | dmem request held until accepted
    // WAIT_D  | waiting for load data or store acknowledge
    // WB      | one-cycle pc_wen / rf_wen strobes
    // HALT    | absorbing until rst; 6 is illegal and lands here with fault

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT_I = 3'd1,
        S_DECODE = 3'd2,
        S_MEM    = 3'd3,
        S_WAIT_D = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [31:0]     NOP      = 32'h0000_0013;

    state_t          r_state;
    logic [31:0]     r_inst;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_rf_wen;
    logic            r_pc_wen;
    logic            r_fault;

    logic            w_to_hit;
    logic [TO_W-1:0] w_to_inc;

    assign w_to_hit = (r_to_cnt == TO_LIMIT);
    assign w_to_inc = w_to_hit ? r_to_cnt : r_to_cnt + TO_W'(1);

    // Counter defaults to clear; only a wait state that holds re-loads it, so any change clears it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_FETCH;
            r_inst   <= NOP;
            r_to_cnt <= '0;
            r_rf_wen <= 1'b0;
            r_pc_wen <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_rf_wen <= 1'b0;
            r_pc_wen <= 1'b0;
            r_to_cnt <= '0;
            case (r_state)
                S_FETCH: begin
                    if (io_mem.imem_req_ready) begin
                        r_state <= S_WAIT_I;
                    end else if (w_to_hit) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_WAIT_I: begin
                    if (io_mem.imem_rsp_valid) begin
                        r_inst  <= io_mem.imem_rsp_data;
                        r_state <= S_DECODE;
                    end else if (w_to_hit) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_DECODE: begin
                    if (i_dec_is_ebreak) begin
                        r_state <= S_HALT;
                    end else if (i_dec_is_mem) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state  <= S_WB;
                        r_pc_wen <= 1'b1;
                        r_rf_wen <= i_dec_wr_rd;
                    end
                end
                S_MEM: begin
                    if (io_mem.dmem_req_ready) begin
                        r_state <= S_WAIT_D;
                    end else if (w_to_hit) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_WAIT_D: begin
                    if (io_mem.dmem_rsp_valid) begin
                        r_state  <= S_WB;
                        r_pc_wen <= 1'b1;
                        r_rf_wen <= i_dec_wr_rd;
                    end else if (w_to_hit) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end else begin
                        r_to_cnt <= w_to_inc;
                    end
                end
                S_WB: begin
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    assign io_mem.imem_req_valid = (r_state == S_FETCH);
    assign io_mem.dmem_req_valid = (r_state == S_MEM);
    assign o_inst                = r_inst;
    assign o_rf_wen              = r_rf_wen;
    assign o_pc_wen              = r_pc_wen;
    assign o_halted              = (r_state == S_HALT);
    assign o_fault               = r_fault;
    assign o_state               = r_state;

`ifdef PERF_CNT_EN
    logic [63:0] r_perf_cycle;
    logic [63:0] r_perf_instret;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perf_cycle   <= '0;
            r_perf_instret <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_perf_cycle <= r_perf_cycle + 64'd1;
            end
            if (r_pc_wen) begin
                r_perf_instret <= r_perf_instret + 64'd1;
            end
        end
    end

    assign o_perf_cycle   = r_perf_cycle;
    assign o_perf_instret = r_perf_instret;
`endif

endmodule
